// File: rtl/avalon_mm_ram_agent.sv
// avalon_mm_ram_agent
//   Avalon-MM responder backed by a word-addressed RAM. Serves as the memory
//   behind a CPU data or instruction host port, in simulation or on an FPGA.
//   Adds programmable command wait states, fixed-latency pipelined reads and
//   byte-lane writes.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active-high (RAM contents survive)
//   address        byte address, bits [1:0] ignored
//   read, write    command strobes (both high is handled as a write)
//   byteenable     write byte lanes, bit i covers data[8i+7:8i]
//   host_to_agent  write data
//   agent_to_host  read data, holds the last returned word between returns
//   waitrequest    command present but not accepted this cycle
//   readdatavalid  agent_to_host carries a read return this cycle
//   error          one-cycle pulse after an out-of-range or read+write command
//
// Wait-state FSM
//   state | meaning
//   IDLE  | no command being stalled; wait_cnt is 0
//   STALL | command held off while wait_cnt counts up to WAIT_CYCLES
module avalon_mm_ram_agent #(
    parameter int    WORDS        = 1024,
    parameter int    READ_LATENCY = 2,
    parameter int    MAX_PENDING  = 4,
    parameter int    WAIT_CYCLES  = 0,
    parameter string INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] host_to_agent,
    output logic [31:0] agent_to_host,
    output logic        waitrequest,
    output logic        readdatavalid,
    output logic        error
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WC_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int PND_W = $clog2(MAX_PENDING + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WC_W-1:0]    wait_cnt_q;
    logic [WC_W-1:0]    wait_cnt_d;
    logic [PND_W-1:0]   pending;

    logic [31:0]        mem [WORDS];
    logic [31:0]        pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [31:0]        last_data;
    logic               error_q;

    logic               cmd;
    logic               accept;
    logic               rd_accept;
    logic               wr_accept;
    logic               in_range;
    logic [IDX_W-1:0]   word_idx;
    logic               unused_addr_lsb;

    assign unused_addr_lsb = ^address[1:0];

    assign word_idx = address[IDX_W+1:2];
    assign in_range = ({2'b00, address[31:2]} < 32'(WORDS));

    assign cmd    = read | write;
    // The full check looks only at the registered count, so a return in the
    // same cycle does not free a slot until the next cycle.
    assign accept = !rst && cmd
                    && (wait_cnt_q == WC_W'(WAIT_CYCLES))
                    && (pending < PND_W'(MAX_PENDING));

    // read+write together is a write; no read data is ever returned for it.
    assign wr_accept = accept && write;
    assign rd_accept = accept && read && !write;

    assign waitrequest   = rst | (cmd & ~accept);
    assign readdatavalid = pipe_valid[READ_LATENCY-1];
    assign agent_to_host = readdatavalid ? pipe_data[READ_LATENCY-1] : last_data;
    assign error         = error_q;

    // ------------------------------------------------------------------
    // Wait-state FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                // With WAIT_CYCLES=0 the command is accepted straight from IDLE.
                if (cmd && !accept && (WAIT_CYCLES != 0)) begin
                    state_d    = STALL;
                    wait_cnt_d = WC_W'(1);
                end
            end
            STALL: begin
                if (!cmd || accept) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != WC_W'(WAIT_CYCLES)) begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
                // Otherwise stalled on a full pipeline: hold the count.
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline control, pending count, error pulse, returned-data hold
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            pending    <= '0;
            last_data  <= '0;
            error_q    <= 1'b0;
        end else begin
            pipe_valid <= (pipe_valid << 1) | READ_LATENCY'(rd_accept);
            case ({rd_accept, readdatavalid})
                2'b10:   pending <= pending + PND_W'(1);
                2'b01:   pending <= pending - PND_W'(1);
                default: pending <= pending;
            endcase
            if (readdatavalid) begin
                last_data <= pipe_data[READ_LATENCY-1];
            end
            error_q <= accept && (!in_range || (read && write));
        end
    end

    // ------------------------------------------------------------------
    // RAM and read data pipeline (no reset: contents survive rst, and a
    // cleared valid bit already discards any in-flight data)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_accept && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    mem[word_idx][8*i +: 8] <= host_to_agent[8*i +: 8];
                end
            end
        end
        // Sampled at the accepting edge, so later writes cannot alter it.
        if (rd_accept) begin
            pipe_data[0] <= in_range ? mem[word_idx] : 32'h0000_0000;
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_avalon_mm_ram_agent.sv
// Directed testbench for avalon_mm_ram_agent. Three instances share clk/rst:
//   0: defaults (WAIT_CYCLES=0, READ_LATENCY=2, MAX_PENDING=4, WORDS=1024)
//   1: WAIT_CYCLES=2
//   2: MAX_PENDING=1, READ_LATENCY=3, WORDS=256
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_avalon_mm_ram_agent;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr  [3];
    logic        rd    [3];
    logic        wr    [3];
    logic [3:0]  be    [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        wreq  [3];
    logic        rvalid[3];
    logic        err   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_mm_ram_agent u_def (
        .clk(clk), .rst(rst), .address(addr[0]), .read(rd[0]), .write(wr[0]),
        .byteenable(be[0]), .host_to_agent(wdata[0]), .agent_to_host(rdata[0]),
        .waitrequest(wreq[0]), .readdatavalid(rvalid[0]), .error(err[0])
    );

    avalon_mm_ram_agent #(.WAIT_CYCLES(2)) u_ws (
        .clk(clk), .rst(rst), .address(addr[1]), .read(rd[1]), .write(wr[1]),
        .byteenable(be[1]), .host_to_agent(wdata[1]), .agent_to_host(rdata[1]),
        .waitrequest(wreq[1]), .readdatavalid(rvalid[1]), .error(err[1])
    );

    avalon_mm_ram_agent #(.WORDS(256), .READ_LATENCY(3), .MAX_PENDING(1)) u_mp (
        .clk(clk), .rst(rst), .address(addr[2]), .read(rd[2]), .write(wr[2]),
        .byteenable(be[2]), .host_to_agent(wdata[2]), .agent_to_host(rdata[2]),
        .waitrequest(wreq[2]), .readdatavalid(rvalid[2]), .error(err[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    // Drive a command from a falling edge and hold it until accepted. Returns
    // at the falling edge of the cycle after acceptance with the strobes low.
    task automatic issue(input int k, input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d, output int waits);
        logic done;
        done  = 1'b0;
        waits = 0;
        rd[k] = r; wr[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (!wreq[k]) done = 1'b1;
            else waits++;
            @(negedge clk);
        end
        rd[k] = 1'b0;
        wr[k] = 1'b0;
        chk1("accept_timeout", done, 1'b1);
    endtask

    task automatic wr_word(input int k, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] d, input int exp_w, input string tag);
        int w;
        issue(k, 1'b0, 1'b1, a, b, d, w);
        chk({tag, "_waits"}, 32'(w), 32'(exp_w));
    endtask

    // Read one word; latency counts cycles from acceptance to readdatavalid.
    task automatic rd_word(input int k, input logic [31:0] a, input logic [31:0] exp_d,
                           input int exp_w, input int exp_l, input string tag);
        int   w;
        int   lat;
        logic got;
        issue(k, 1'b1, 1'b0, a, 4'hF, 32'h0, w);
        chk({tag, "_waits"}, 32'(w), 32'(exp_w));
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (rvalid[k]) begin
                got = 1'b1;
                chk({tag, "_data"}, rdata[k], exp_d);
            end else begin
                lat++;
            end
            @(negedge clk);
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_l));
    endtask

    initial begin
        int w;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            addr[k] = '0; rd[k] = 1'b0; wr[k] = 1'b0; be[k] = '0; wdata[k] = '0;
        end

        // Reset values
        @(negedge clk);
        #1;
        chk1("rst_wreq", wreq[0], 1'b1);
        chk1("rst_rvalid", rvalid[0], 1'b0);
        chk("rst_rdata", rdata[0], 32'h0);
        chk1("rst_err", err[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic write then read
        wr_word(0, 32'h10, 4'hF, 32'h1234_5678, 0, "basic_wr");
        #1 chk1("basic_wr_noerr", err[0], 1'b0);
        @(negedge clk);
        rd_word(0, 32'h10, 32'h1234_5678, 0, 2, "basic_rd");
        #1;
        chk1("hold_rvalid", rvalid[0], 1'b0);
        chk("hold_rdata", rdata[0], 32'h1234_5678);
        @(negedge clk);

        // Byte lanes
        wr_word(0, 32'h14, 4'hF, 32'h1122_3344, 0, "lane_init");
        wr_word(0, 32'h14, 4'b0101, 32'hAABB_CCDD, 0, "lane_wr");
        rd_word(0, 32'h14, 32'h11BB_33DD, 0, 2, "lane_rd");
        wr_word(0, 32'h14, 4'b0000, 32'hFFFF_FFFF, 0, "be0_wr");
        rd_word(0, 32'h14, 32'h11BB_33DD, 0, 2, "be0_rd");

        // Read followed immediately by a write to the same word
        wr_word(0, 32'h20, 4'hF, 32'd5, 0, "raw_init");
        rd[0] = 1'b1; addr[0] = 32'h20;
        #1 chk1("raw_rd_acc", wreq[0], 1'b0);
        @(negedge clk);
        rd[0] = 1'b0; wr[0] = 1'b1; wdata[0] = 32'd9; be[0] = 4'hF;
        #1;
        chk1("raw_wr_acc", wreq[0], 1'b0);
        chk1("raw_early", rvalid[0], 1'b0);
        @(negedge clk);
        wr[0] = 1'b0;
        #1;
        chk1("raw_rvalid", rvalid[0], 1'b1);
        chk("raw_old_data", rdata[0], 32'd5);
        @(negedge clk);
        rd_word(0, 32'h20, 32'd9, 0, 2, "raw_new");

        // Out-of-range write dropped, read returns zero, error pulses
        wr_word(0, 32'h0, 4'hF, 32'h55, 0, "oor_pre");
        issue(0, 1'b0, 1'b1, 32'd4096, 4'hF, 32'hDEAD, w);
        #1 chk1("oor_wr_err", err[0], 1'b1);
        @(negedge clk);
        #1 chk1("oor_wr_err_clr", err[0], 1'b0);
        @(negedge clk);
        issue(0, 1'b1, 1'b0, 32'd4096, 4'hF, 32'h0, w);
        #1;
        chk1("oor_rd_err", err[0], 1'b1);
        chk1("oor_rd_early", rvalid[0], 1'b0);
        @(negedge clk);
        #1;
        chk1("oor_rd_rvalid", rvalid[0], 1'b1);
        chk("oor_rd_data", rdata[0], 32'h0);
        @(negedge clk);
        rd_word(0, 32'h0, 32'h55, 0, 2, "oor_alias");

        // read and write together: a write, error, no return
        issue(0, 1'b1, 1'b1, 32'h30, 4'hF, 32'h77, w);
        #1 chk1("both_err", err[0], 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1 chk1($sformatf("both_norv_%0d", c), rvalid[0], 1'b0);
            @(negedge clk);
        end
        rd_word(0, 32'h30, 32'h77, 0, 2, "both_data");

        // WAIT_CYCLES=2: four back-to-back reads
        for (int j = 0; j < 4; j++) begin
            wr_word(1, 32'h100 + 32'(4*j), 4'hF, 32'hA0 + 32'(j), 2, $sformatf("ws_pre%0d", j));
        end
        for (int c = 0; c < 15; c++) begin
            rd[1]   = (c < 12);
            addr[1] = 32'h100 + 32'(4*(c/3));
            #1;
            chk1($sformatf("ws_wreq_c%0d", c), wreq[1], (c < 12) && (c % 3 != 2));
            chk1($sformatf("ws_rvalid_c%0d", c), rvalid[1], (c >= 4) && ((c - 4) % 3 == 0));
            if ((c >= 4) && ((c - 4) % 3 == 0))
                chk($sformatf("ws_data_c%0d", c), rdata[1], 32'hA0 + 32'((c - 4) / 3));
            @(negedge clk);
        end
        rd[1] = 1'b0;

        // MAX_PENDING=1, READ_LATENCY=3: second read waits for the first return
        wr_word(2, 32'h200, 4'hF, 32'hB1, 0, "mp_preA");
        wr_word(2, 32'h204, 4'hF, 32'hB2, 0, "mp_preB");
        for (int c = 0; c < 9; c++) begin
            rd[2]   = (c < 5);
            addr[2] = (c == 0) ? 32'h200 : 32'h204;
            #1;
            chk1($sformatf("mp_wreq_c%0d", c), wreq[2], (c >= 1) && (c <= 3));
            chk1($sformatf("mp_rvalid_c%0d", c), rvalid[2], (c == 3) || (c == 7));
            if (c == 3) chk("mp_dataA", rdata[2], 32'hB1);
            if (c == 7) chk("mp_dataB", rdata[2], 32'hB2);
            @(negedge clk);
        end
        rd[2] = 1'b0;

        // Reset with two reads in flight (and instance 1 mid-stall)
        rd[0] = 1'b1; addr[0] = 32'h10;
        rd[1] = 1'b1; addr[1] = 32'h100;
        #1 chk1("inflight_acc0", wreq[0], 1'b0);
        @(negedge clk);
        addr[0] = 32'h14;
        #1 chk1("inflight_acc1", wreq[0], 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rd[0] = 1'b0;
        rd[1] = 1'b0;
        #1;
        chk1("mid_rst_rvalid", rvalid[0], 1'b0);
        chk("mid_rst_rdata", rdata[0], 32'h0);
        chk1("mid_rst_wreq", wreq[1], 1'b1);
        chk1("mid_rst_err", err[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1 chk1($sformatf("post_rst_norv_%0d", c), rvalid[0], 1'b0);
            @(negedge clk);
        end
        rd_word(0, 32'h10, 32'h1234_5678, 0, 2, "post_rst_ram");
        rd_word(1, 32'h100, 32'hA0, 2, 2, "post_rst_ws");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
